argon_alu_seq: RTL

//  Parametrised, handshaked sequential ALU for Argon v2; successor to the fixed 16-bit ALU.

---
 rtl/argon_pkg.sv | 33 +++
 rtl/argon_alu_comb.sv | 86 ++++++++
 rtl/argon_alu_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/argon_pkg.sv
// Shared Argon definitions: flag bit positions, ALU opcodes and the sequencer state type.
package argon_pkg;

    localparam int NFLAGS    = 6;
    localparam int F_CARRY   = 0;
    localparam int F_ZERO    = 1;
    localparam int F_EQUAL   = 2;
    localparam int F_GREATER = 3;
    localparam int F_LESS    = 4;
    localparam int F_BORROW  = 5;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} alu_state_t;

    // Plain 4-bit vector so reserved encodings 0xD-0xF remain representable.
    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_ADD  = 4'h0;
    localparam alu_op_t ALU_ADC  = 4'h1;
    localparam alu_op_t ALU_SBC  = 4'h2;
    localparam alu_op_t ALU_CMP  = 4'h3;
    localparam alu_op_t ALU_INC  = 4'h4;
    localparam alu_op_t ALU_DEC  = 4'h5;
    localparam alu_op_t ALU_NAND = 4'h6;
    localparam alu_op_t ALU_AND  = 4'h7;
    localparam alu_op_t ALU_OR   = 4'h8;
    localparam alu_op_t ALU_NOR  = 4'h9;
    localparam alu_op_t ALU_XOR  = 4'hA;
    localparam alu_op_t ALU_LSH  = 4'hB;
    localparam alu_op_t ALU_RSH  = 4'hC;

    localparam alu_op_t ALU_LAST_LEGAL = ALU_RSH;

endpackage

// File: rtl/argon_alu_comb.sv
// Single-step combinational ALU datapath. Shifts move one bit when the amount is
// non-zero and pass A through otherwise; the sequencer iterates them.
module argon_alu_comb
    import argon_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int NFLAGS  = argon_pkg::NFLAGS
) (
    input  alu_op_t           op_i,
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    input  logic [NFLAGS-1:0] flags_i,
    output logic [WIDTH-1:0]  result_o,
    output logic [NFLAGS-1:0] flags_o,
    output logic              illegal_o
);

    localparam logic [WIDTH:0] ONE_W = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH:0]       wide;
    logic [SHAMT_W-1:0]   shamt;

    assign shamt = b_i[SHAMT_W-1:0];

    always_comb begin
        wide      = '0;
        result_o  = '0;
        flags_o   = flags_i;
        illegal_o = 1'b0;
        unique case (op_i)
            ALU_ADD, ALU_ADC: begin
                wide = {1'b0, a_i} + {1'b0, b_i}
                     + {{WIDTH{1'b0}}, (op_i == ALU_ADC) & flags_i[F_CARRY]};
                result_o          = wide[WIDTH-1:0];
                flags_o[F_CARRY]  = wide[WIDTH];
                flags_o[F_BORROW] = 1'b0;
            end
            ALU_SBC: begin
                // Bit WIDTH of the extended difference is set exactly when a < b + bin.
                wide = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, flags_i[F_BORROW]};
                result_o          = wide[WIDTH-1:0];
                flags_o[F_BORROW] = wide[WIDTH];
                flags_o[F_CARRY]  = ~wide[WIDTH];
            end
            ALU_CMP: begin
                result_o           = a_i;
                flags_o[F_EQUAL]   = (a_i == b_i);
                flags_o[F_GREATER] = (a_i > b_i);
                flags_o[F_LESS]    = (a_i < b_i);
            end
            ALU_INC: begin
                wide             = {1'b0, a_i} + ONE_W;
                result_o         = wide[WIDTH-1:0];
                flags_o[F_CARRY] = wide[WIDTH];
            end
            ALU_DEC: begin
                wide              = {1'b0, a_i} - ONE_W;
                result_o          = wide[WIDTH-1:0];
                flags_o[F_BORROW] = wide[WIDTH];
            end
            ALU_NAND, ALU_AND, ALU_OR, ALU_NOR, ALU_XOR: begin
                case (op_i)
                    ALU_NAND: result_o = ~(a_i & b_i);
                    ALU_AND:  result_o = a_i & b_i;
                    ALU_OR:   result_o = a_i | b_i;
                    ALU_NOR:  result_o = ~(a_i | b_i);
                    default:  result_o = a_i ^ b_i;
                endcase
                flags_o[F_CARRY]  = 1'b0;
                flags_o[F_BORROW] = 1'b0;
            end
            ALU_LSH: begin
                result_o         = (shamt != '0) ? {a_i[WIDTH-2:0], 1'b0} : a_i;
                flags_o[F_CARRY] = (shamt != '0) & a_i[WIDTH-1];
            end
            ALU_RSH: begin
                result_o         = (shamt != '0) ? {1'b0, a_i[WIDTH-1:1]} : a_i;
                flags_o[F_CARRY] = (shamt != '0) & a_i[0];
            end
            default: illegal_o = 1'b1;
        endcase
        if (!illegal_o) flags_o[F_ZERO] = (result_o == '0);
    end

endmodule

// File: rtl/argon_alu_seq.sv
// Handshaked sequential ALU: accepts one op, iterates multi-bit shifts one bit per
// cycle, then holds result and flag register until the consumer takes them.
module argon_alu_seq
    import argon_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int NFLAGS  = argon_pkg::NFLAGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [3:0]        i_op,
    input  logic [WIDTH-1:0]  i_a,
    input  logic [WIDTH-1:0]  i_b,
    input  logic              i_flags_clr,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [WIDTH-1:0]  o_result,
    output logic [NFLAGS-1:0] o_flags,
    output logic              o_illegal
);

    localparam logic [SHAMT_W-1:0] CNT_ONE   = {{(SHAMT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   STEP_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    alu_state_t          state_q, state_d;
    alu_op_t             op_q, op_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic [NFLAGS-1:0]   flags_q, flags_d, flags_eff;
    logic                illegal_q, illegal_d;
    logic [SHAMT_W-1:0]  cnt_q, cnt_d;

    alu_op_t             c_op;
    logic [WIDTH-1:0]    c_a, c_b, c_result;
    logic [NFLAGS-1:0]   c_flags_in, c_flags_out;
    logic                c_illegal;
    logic                is_shift;

    argon_alu_comb #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .NFLAGS(NFLAGS)) u_comb (
        .op_i     (c_op),
        .a_i      (c_a),
        .b_i      (c_b),
        .flags_i  (c_flags_in),
        .result_o (c_result),
        .flags_o  (c_flags_out),
        .illegal_o(c_illegal)
    );

    assign flags_eff = i_flags_clr ? '0 : flags_q;
    assign is_shift  = ((i_op == ALU_LSH) || (i_op == ALU_RSH)) && (i_b[SHAMT_W-1:0] != '0);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        result_d   = result_q;
        flags_d    = flags_q;
        illegal_d  = illegal_q;
        cnt_d      = cnt_q;
        c_op       = i_op;
        c_a        = i_a;
        c_b        = i_b;
        c_flags_in = flags_eff;
        case (state_q)
            IDLE: begin
                flags_d = flags_eff;
                if (i_valid) begin
                    op_d = i_op;
                    if (is_shift) begin
                        result_d  = i_a;
                        cnt_d     = i_b[SHAMT_W-1:0];
                        illegal_d = 1'b0;
                        state_d   = SHIFT;
                    end else begin
                        result_d  = c_result;
                        flags_d   = c_flags_out;
                        illegal_d = c_illegal;
                        state_d   = HOLD;
                    end
                end
            end
            SHIFT: begin
                // Iterate a 1-bit step on the accumulator; flags land only with the final step.
                c_op       = op_q;
                c_a        = result_q;
                c_b        = STEP_ONE;
                c_flags_in = flags_q;
                result_d   = c_result;
                cnt_d      = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    flags_d = c_flags_out;
                    state_d = HOLD;
                end
            end
            HOLD:    if (i_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            result_q  <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge clk) op_q <= op_d;

    assign o_ready   = (state_q == IDLE);
    assign o_valid   = (state_q == HOLD);
    assign o_result  = result_q;
    assign o_flags   = flags_q;
    assign o_illegal = illegal_q;

endmodule
